io_button_reader: RTL and testbench
===================================

# io_button_reader

Input-side companion to the LED counter user designs. It samples the board's asynchronous push-button and slide-switch pins, synchronises and debounces them, and emits one clean pulse per button press. It also keeps a wrapping up/down press count that the enclosing top drives onto the LED pins. It is instantiated in a `top` between `io_in[PIN_BUTTON]`/`io_in[PIN_SWITCH]` and the LED `io_out` bits.

## Interface
- `DEBOUNCE_CYCLES`, 50000: cycles a synchronised input must stay unchanged before its debounced level follows; legal range ≥ 2.
- `COUNT_WIDTH`, 10: width of the press counter; matches the lower LED field.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `btn_raw`  in  1  raw button pin, asynchronous to `clk`.
- `sw_raw`  in  1  raw switch pin, asynchronous to `clk`.
- `en`  in  1  count enable, synchronous, level.
- `btn_level`  out  1  debounced button level.
- `sw_level`  out  1  debounced switch level; 0 selects count up, 1 selects count down.
- `press_pulse`  out  1  one-cycle pulse on each debounced button rising edge.
- `count`  out  COUNT_WIDTH  press counter.

## Operation
- **Synchronisers.** Each raw input passes through a 2-FF synchroniser. Both stages reset to 0.
- **Debounce FSM.** There is one FSM per input, with counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`. States and transitions:
  - STABLE_LO, level 0: if sync = 1, go to WAIT_HI with `cnt`←0.
  - WAIT_HI, level 0: if sync = 0, return to STABLE_LO. Else if `cnt` = DEBOUNCE_CYCLES−1, go to STABLE_HI. Else `cnt`+1.
  - STABLE_HI, level 1: if sync = 0, go to WAIT_LO with `cnt`←0.
  - WAIT_LO, level 1: mirror of WAIT_HI; on completion go to STABLE_LO.
- **Press pulse.** `press_pulse` is registered and is 1 exactly on the cycle following the button FSM's WAIT_HI→STABLE_HI transition. Debounced falling edges produce no pulse.
- **Counting.**
  - The count updates at the same clock edge that raises `press_pulse`, and only if `en` = 1 at that edge.
  - Direction comes from the `sw_level` value registered before that edge.
  - The counter wraps modulo 2^COUNT_WIDTH: 0 − 1 gives 2^COUNT_WIDTH−1, and all-ones + 1 gives 0.
- **Enable low.** With `en` = 0, `press_pulse` still fires and `count` holds.
- **Switch change at a press.** If the switch finishes debouncing at the same edge as a press, the old `sw_level` decides the direction.
- **Reset values.** When `rst_n` = 0 at an edge, all state is cleared:
  - `btn_level`, `sw_level`, `press_pulse` = 0 and `count` = 0.
  - Both FSMs return to STABLE_LO and both synchronisers are cleared.
- **Reset mid-operation.** Reset aborts any debounce in progress. A button held through reset release must debounce again from STABLE_LO and then produces exactly one pulse.
- **Glitches.** A sync high lasting fewer than DEBOUNCE_CYCLES+1 consecutive cycles produces no level change and no pulse.

## Timing
Edge 0 is the first edge that samples `btn_raw` = 1; the input is held thereafter.
- Edge 1: sync = 1.
- Edge 2: the FSM enters WAIT_HI.
- Edge D+2 (D = DEBOUNCE_CYCLES): `btn_level`, `press_pulse` and `count` update together.
- Edge D+3: `press_pulse` returns to 0.
- Release latency is symmetric: `btn_level` falls after edge D+2 from the first 0 sample.
- The switch path has the same latency.
- No combinational path from any input to any output.

## Structure
- **Package `io_pins_pkg`** holds:
  - Pin constants `PIN_RESET`=23, `PIN_ENABLE`=22, `PIN_SWITCH`=11, `PIN_BUTTON`=10.
  - `OUTPUT_ENABLE`=1 and `OUTPUT_DISABLE`=0.
  - The debounce state enum {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO}.
- **Sub-module `debounce_filter`** (parameter DEBOUNCE_CYCLES) contains synchroniser, FSM and counter.
  - Ports: `clk`, `rst_n`, `raw`, `level`, `rise`.
  - It is instantiated twice, for button and switch.
  - `io_button_reader` adds the pulse register and the up/down counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and COUNT_WIDTH = 10.
- **Clean press.** After reset, hold `btn_raw` = 1 with `en` = 1 and `sw_raw` = 0.
  - `press_pulse` is high for exactly one cycle, after edge 6.
  - `count` goes 0→1 at that edge. Release produces no pulse, and `btn_level` drops 6 edges after release.
- **Bounce rejection.** Drive `btn_raw` in the pattern 1,1,0,1,1,1,0 cycle by cycle, then hold 0.
  - No pulse, `btn_level` stays 0, `count` stays 0.
- **Down-count and wrap.** Debounce `sw_raw` = 1, then make one press from `count` = 0.
  - `count` = 1023. A following press with switch 0 makes it 1023→0 on the next up press (0→1 overall after two presses).
- **Enable gating.** Press with `en` = 0.
  - `press_pulse` fires, `count` is unchanged.
  - Press again with `en` = 1: `count` +1.
- **Reset mid-debounce.** Hold the button and assert `rst_n` = 0 for one cycle at edge 4, then release reset with the button still held.
  - No pulse before reset.
  - Exactly one pulse 6 edges after the first post-reset sample, with `count` = 1.
- **Simultaneous switch and press.** The switch debounce completes at the same edge as a button press.
  - The count moves in the old direction: +1 if `sw_level` was 0.

Source files
------------

// File: rtl/io_pins_pkg.sv
// Board pin map, output-enable constants and debounce state encoding.
package io_pins_pkg;

    localparam int PIN_RESET  = 23;
    localparam int PIN_ENABLE = 22;
    localparam int PIN_SWITCH = 11;
    localparam int PIN_BUTTON = 10;

    localparam logic OUTPUT_ENABLE  = 1'b1;
    localparam logic OUTPUT_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } debounce_state_e;

endpackage

// File: rtl/io_button_reader_if.sv
// Button/switch reader bus: raw pins and enable in, clean levels, pulse and count out.
interface io_button_reader_if #(
    parameter int COUNT_WIDTH = 10
);
    logic                   btn_raw;
    logic                   sw_raw;
    logic                   en;
    logic                   btn_level;
    logic                   sw_level;
    logic                   press_pulse;
    logic [COUNT_WIDTH-1:0] count;

    modport master (
        output btn_raw, sw_raw, en,
        input  btn_level, sw_level, press_pulse, count
    );

    modport slave (
        input  btn_raw, sw_raw, en,
        output btn_level, sw_level, press_pulse, count
    );
endinterface

// File: rtl/debounce_filter.sv
// 2-FF synchroniser followed by a four-state debounce FSM for one raw pin.
module debounce_filter
    import io_pins_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_STABLE_LO = STABLE_LO;
    localparam logic [1:0] ST_WAIT_HI   = WAIT_HI;
    localparam logic [1:0] ST_STABLE_HI = STABLE_HI;
    localparam logic [1:0] ST_WAIT_LO   = WAIT_LO;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level only follows once the synchronised pin has held its new value long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_STABLE_LO: begin
                    if (r_sync2) begin
                        r_state <= ST_WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (!r_sync2)       r_state <= ST_STABLE_LO;
                    else if (w_cnt_last) r_state <= ST_STABLE_HI;
                    else                r_cnt   <= r_cnt + CW'(1);
                end
                ST_STABLE_HI: begin
                    if (!r_sync2) begin
                        r_state <= ST_WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (r_sync2)        r_state <= ST_STABLE_HI;
                    else if (w_cnt_last) r_state <= ST_STABLE_LO;
                    else                r_cnt   <= r_cnt + CW'(1);
                end
            endcase
        end
    end

    // Level decodes from state alone, so no input reaches it combinationally.
    assign level = (r_state == ST_STABLE_HI) || (r_state == ST_WAIT_LO);
    // High during the cycle whose edge completes a rising debounce.
    assign rise  = (r_state == ST_WAIT_HI) && r_sync2 && w_cnt_last;

endmodule

// File: rtl/io_button_reader.sv
// Debounced button/switch reader with press pulse and wrapping up/down press counter.
module io_button_reader
    import io_pins_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COUNT_WIDTH     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    io_button_reader_if.slave bus
);
    logic                   w_btn_level;
    logic                   w_btn_rise;
    logic                   w_sw_level;
    logic                   w_sw_rise_unused;
    logic                   r_pulse;
    logic [COUNT_WIDTH-1:0] r_count;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_raw),
        .level (w_btn_level),
        .rise  (w_btn_rise)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.sw_raw),
        .level (w_sw_level),
        .rise  (w_sw_rise_unused)
    );

    // One-cycle pulse following each completed button press.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pulse <= 1'b0;
        else        r_pulse <= w_btn_rise;
    end

    // Count on the press edge; w_sw_level is still the pre-edge value, so a
    // switch settling on the same edge does not change this press's direction.
    always_ff @(posedge clk) begin
        if (!rst_n)                   r_count <= '0;
        else if (w_btn_rise && bus.en) r_count <= w_sw_level ? r_count - COUNT_WIDTH'(1)
                                                             : r_count + COUNT_WIDTH'(1);
    end

    assign bus.btn_level   = w_btn_level;
    assign bus.sw_level    = w_sw_level;
    assign bus.press_pulse = r_pulse;
    assign bus.count       = r_count;

endmodule

// File: tb/tb_io_button_reader.sv
// Scoreboard bench for io_button_reader: directed scenarios plus random pin activity.
module tb_io_button_reader;
    localparam int D   = 4;
    localparam int CWD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_button_reader_if #(.COUNT_WIDTH(CWD)) bus ();

    io_button_reader #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CWD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic           btn_level;
        logic           sw_level;
        logic           pulse;
        logic [CWD-1:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses_seen = 0;
    int   cyc         = 0;

    // Reference model: each pin is seen by the filter two edges late; the level
    // flips once the filter has seen D+1 consecutive samples opposite to it.
    logic           m_b1, m_b2, m_s1, m_s2;
    logic           m_bl, m_sl, m_pulse;
    int             m_brun, m_srun;
    logic [CWD-1:0] m_cnt;

    function automatic void filt(input logic smp, input logic lvl_in, input int run_in,
                                 output logic lvl, output int run, output logic rose);
        lvl  = lvl_in;
        rose = 1'b0;
        run  = (smp != lvl_in) ? run_in + 1 : 0;
        if (run == D + 1) begin
            lvl  = smp;
            rose = smp;
            run  = 0;
        end
    endfunction

    task automatic model_edge(input logic r, input logic b, input logic s, input logic e);
        logic nbl, nsl, brose, srose;
        int   nbr, nsr;
        if (!r) begin
            m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
            m_bl = 0; m_sl = 0; m_pulse = 0; m_brun = 0; m_srun = 0; m_cnt = '0;
        end else begin
            filt(m_b2, m_bl, m_brun, nbl, nbr, brose);
            filt(m_s2, m_sl, m_srun, nsl, nsr, srose);
            m_pulse = brose;
            if (brose && e) m_cnt = m_sl ? m_cnt - 1'b1 : m_cnt + 1'b1;
            m_bl = nbl; m_brun = nbr;
            m_sl = nsl; m_srun = nsr;
            m_b2 = m_b1; m_b1 = b;
            m_s2 = m_s1; m_s1 = s;
        end
    endtask

    // Apply one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic r, input logic b, input logic s, input logic e);
        exp_t x;
        @(negedge clk);
        rst_n = r; bus.btn_raw = b; bus.sw_raw = s; bus.en = e;
        model_edge(r, b, s, e);
        x.btn_level = m_bl; x.sw_level = m_sl; x.pulse = m_pulse; x.count = m_cnt;
        sb_q.push_back(x);
    endtask

    task automatic hold(input int n, input logic r, input logic b, input logic s, input logic e);
        repeat (n) step(r, b, s, e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: after every edge compare the DUT outputs with the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if ({bus.btn_level, bus.sw_level, bus.press_pulse, bus.count} !== e) begin
                    miscompares++;
                    $display("FAIL cycle_%0d: got bl=%b sl=%b p=%b cnt=%0d, expected bl=%b sl=%b p=%b cnt=%0d",
                             cyc, bus.btn_level, bus.sw_level, bus.press_pulse, bus.count,
                             e.btn_level, e.sw_level, e.pulse, e.count);
                end
                if (bus.press_pulse === 1'b1) pulses_seen++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0;
        bus.btn_raw = 0; bus.sw_raw = 0; bus.en = 1; rst_n = 0;
        hold(3, 0, 0, 0, 1);
        chk("reset_count", int'(bus.count), 0);
        chk("reset_btn_level", int'(bus.btn_level), 0);
        chk("reset_pulse", int'(bus.press_pulse), 0);

        // Clean press and release.
        p0 = pulses_seen;
        hold(10, 1, 1, 0, 1);
        chk("clean_pulses", pulses_seen - p0, 1);
        chk("clean_count", int'(bus.count), 1);
        chk("clean_level_hi", int'(bus.btn_level), 1);
        hold(10, 1, 0, 0, 1);
        chk("release_pulses", pulses_seen - p0, 1);
        chk("release_level_lo", int'(bus.btn_level), 0);

        // Bounce rejection.
        p0 = pulses_seen;
        step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
        step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
        hold(8, 1, 0, 0, 1);
        chk("bounce_pulses", pulses_seen - p0, 0);
        chk("bounce_count", int'(bus.count), 1);

        // Down-count wrap from zero, then back up.
        hold(2, 0, 0, 0, 1);
        hold(10, 1, 0, 1, 1);
        chk("sw_level_hi", int'(bus.sw_level), 1);
        hold(10, 1, 1, 1, 1);
        hold(10, 1, 0, 1, 1);
        chk("wrap_down", int'(bus.count), 1023);
        hold(10, 1, 0, 0, 1);
        hold(10, 1, 1, 0, 1);
        hold(10, 1, 0, 0, 1);
        chk("wrap_up", int'(bus.count), 0);
        hold(10, 1, 1, 0, 1);
        hold(10, 1, 0, 0, 1);
        chk("wrap_up2", int'(bus.count), 1);

        // Enable gating.
        p0 = pulses_seen;
        hold(10, 1, 1, 0, 0);
        hold(10, 1, 0, 0, 0);
        chk("en0_pulses", pulses_seen - p0, 1);
        chk("en0_count", int'(bus.count), 1);
        hold(10, 1, 1, 0, 1);
        hold(10, 1, 0, 0, 1);
        chk("en1_count", int'(bus.count), 2);

        // Reset in the middle of a debounce, button held through release.
        p0 = pulses_seen;
        hold(4, 1, 1, 0, 1);
        chk("midrst_prepulses", pulses_seen - p0, 0);
        step(0, 1, 0, 1);
        hold(12, 1, 1, 0, 1);
        chk("midrst_pulses", pulses_seen - p0, 1);
        chk("midrst_count", int'(bus.count), 1);
        hold(10, 1, 0, 0, 1);

        // Switch and button settle on the same edge: old direction applies.
        hold(10, 1, 1, 1, 1);
        chk("simul_up", int'(bus.count), 2);
        chk("simul_sw_hi", int'(bus.sw_level), 1);
        hold(10, 1, 0, 1, 1);
        hold(10, 1, 1, 0, 1);
        chk("simul_down", int'(bus.count), 1);
        hold(10, 1, 0, 0, 1);

        // Random pin activity with occasional resets.
        for (int i = 0; i < 400; i++) begin
            int   len;
            logic b, s, e, r;
            len = $urandom_range(1, 12);
            b   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 5) == 0) ? ~bus.sw_raw : bus.sw_raw;
            e   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 60) != 0);
            if (!r) step(0, b, s, e);
            hold(len, 1, b, s, e);
        end
        hold(12, 1, 0, 0, 1);

        @(posedge clk);
        #2;
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
